// File: rtl/tff_mod_counter_pkg.sv
// Shared definitions for the toggle-cell modulo counter: default count type
// and the direction encoding used on the up input.
package tff_mod_counter_pkg;

    localparam int DEFAULT_WIDTH = 4;

    typedef logic [DEFAULT_WIDTH-1:0] count_t;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

endpackage : tff_mod_counter_pkg

// File: rtl/tff_mod_counter_tff_cell.sv
// Single toggle bit: inverts on t=1, synchronous active-low clear.
module tff_cell
    import tff_mod_counter_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic t,
    output logic q
);

    logic r_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_q <= 1'b0;
        end else if (t) begin
            r_q <= ~r_q;
        end
    end

    assign q = r_q;

endmodule : tff_cell

// File: rtl/tff_mod_counter.sv
// Modulo up/down counter built from a bank of toggle cells. The next count is
// chosen combinationally and turned into a toggle vector against the current q.
module tff_mod_counter
    import tff_mod_counter_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] q,
    output logic             wrap
);

    if (MODULUS < 2 || MODULUS > (2 ** WIDTH)) begin : g_bad_modulus
        $error("tff_mod_counter: MODULUS must be in 2..2**WIDTH");
    end

    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);

    logic [WIDTH-1:0] w_q;
    logic [WIDTH-1:0] w_next;
    logic [WIDTH-1:0] w_t;
    logic             w_wrap_next;
    logic             r_wrap;

    always_comb begin
        w_next      = w_q;
        w_wrap_next = 1'b0;
        if (load) begin
            w_next = (load_val > MAX_VAL) ? MAX_VAL : load_val;
        end else if (en) begin
            if (up == DIR_UP) begin
                if (w_q == MAX_VAL) begin
                    w_next      = '0;
                    w_wrap_next = 1'b1;
                end else begin
                    w_next = w_q + WIDTH'(1);
                end
            end else begin
                if (w_q == '0) begin
                    w_next      = MAX_VAL;
                    w_wrap_next = 1'b1;
                end else begin
                    w_next = w_q - WIDTH'(1);
                end
            end
        end
    end

    // Only bits that differ between current and next count toggle this edge.
    assign w_t = w_q ^ w_next;

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cells
        tff_cell u_cell (
            .clk   (clk),
            .rst_n (rst_n),
            .t     (w_t[gi]),
            .q     (w_q[gi])
        );
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wrap <= 1'b0;
        end else begin
            r_wrap <= w_wrap_next;
        end
    end

    assign q    = w_q;
    assign wrap = r_wrap;

endmodule : tff_mod_counter

// File: doc/tff_mod_counter.md
# tff_mod_counter

Synchronous modulo up/down counter built from per-bit toggle cells. It is the downstream consumer stage of the T flip-flop: a bank of toggle cells plus the toggle-enable logic that drives them. It provides a loadable, enable-gated count with a one-cycle wrap flag for cascading.

## Interface
Parameters:
- WIDTH, 4, counter width in bits
- MODULUS, 10, count range 0..MODULUS-1; legal range 2 ≤ MODULUS ≤ 2**WIDTH

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  reset; one clock, synchronous, active-low
- en  input  1  count enable; one step per cycle while high
- up  input  1  direction: 1 = increment, 0 = decrement
- load  input  1  synchronous parallel load
- load_val  input  WIDTH  value taken on load
- q  output  WIDTH  current count, registered
- wrap  output  1  registered one-cycle pulse after a wrap step

## Operation
Priority per rising clk edge: reset > load > en > hold.
- Reset (rst_n=0 at the edge): q=0, wrap=0. Other inputs are ignored.
- Load: q=min(load_val, MODULUS-1). A load_val ≥ MODULUS saturates to MODULUS-1. wrap=0 in the following cycle. en is ignored in the load cycle.
- Count up (en=1, up=1): if q==MODULUS-1, then q becomes 0 and wrap=1. Otherwise q becomes q+1.
- Count down (en=1, up=0): if q==0, then q becomes MODULUS-1 and wrap=1. Otherwise q becomes q-1.
- Hold (en=0, load=0): q unchanged, wrap=0.
- wrap is high for exactly one cycle per wrap step. Back-to-back wraps (e.g. MODULUS=2, continuous count) give wrap high on consecutive cycles.
- Arithmetic is unsigned WIDTH-bit. With MODULUS == 2**WIDTH, the wrap compare still uses MODULUS-1 (all ones), so natural binary rollover behaves identically.
- Toggle realisation: next = the value selected above; toggle vector t = q XOR next. Each bit is a toggle cell that inverts when its t bit is 1. Reset and load are applied through the cells' synchronous clear and toggle inputs, never asynchronously.
- No state machine beyond the count register. q never takes a value ≥ MODULUS, even transiently at a register boundary.

## Timing
- All outputs come from flops. No combinational path from inputs to outputs.
- Latency: an input sampled at edge N is reflected on q and wrap immediately after edge N (1 cycle).
- A direction change takes effect on the same edge it is sampled. Mid-count reversal needs no idle cycle.
- Reset mid-count: q=0 after the edge regardless of en/load. wrap is cleared even if a wrap step would have occurred.
- load and en both high: load wins and no wrap is generated.
- rst_n is released synchronously; counting resumes on the first edge with rst_n=1 and en=1.

## Structure
- Shared package: the WIDTH-derived count type and the direction encoding (DIR_UP=1, DIR_DOWN=0).
- One natural sub-module: tff_cell (ports clk, rst_n, t, q). It is a single toggle bit with synchronous active-low clear, instantiated WIDTH times through a generate loop.
- Top level holds the next-value mux, the saturation compare, the wrap detect and the wrap flop.
- Elaboration-time check: fail if MODULUS < 2 or MODULUS > 2**WIDTH.

## Test plan
- Reset: hold rst_n=0 for 3 edges with en=1, up=1 -> q=0 and wrap=0 throughout. Release; 3 enabled edges -> q=1,2,3.
- Up wrap (WIDTH=4, MODULUS=10): from q=0, 10 enabled up edges -> q steps to 9, then 0. wrap=1 only in the cycle q returns to 0. Total of exactly one pulse.
- Down wrap: load 0, then 2 down edges -> q=9 with wrap=1, then q=8 with wrap=0.
- Load saturation and priority: load=1, en=1, load_val=13 -> q=9, wrap=0. Next, load=0, en=1, up=1 -> q=0, wrap=1.
- Hold and reversal: q=5, en=0 for 4 edges -> q stays 5. Then alternate up=1/0 each edge with en=1 -> q=6,5,6,5.
- Full-range and mid-op reset (WIDTH=3, MODULUS=8): count up from 6 -> 7, then 0 with wrap. Assert rst_n=0 at q=7 with en=1 -> q=0, wrap=0.
